// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types and helpers for the raster timing generator.
package video_timing_pkg;

    localparam int VT_CW = 16;

    typedef struct packed {
        logic [VT_CW-1:0] hsw;
        logic [VT_CW-1:0] hbp;
        logic [VT_CW-1:0] hact;
        logic [VT_CW-1:0] hfp;
        logic [VT_CW-1:0] vsw;
        logic [VT_CW-1:0] vbp;
        logic [VT_CW-1:0] vact;
        logic [VT_CW-1:0] vfp;
    } vt_cfg_t;

    typedef enum logic [1:0] {PH_SYNC, PH_BP, PH_ACT, PH_FP} vt_phase_e;

    typedef enum logic {ST_IDLE, ST_RUN} vt_state_e;

    // A zero-length phase would stall the raster, so it is stretched to one unit.
    function automatic logic [VT_CW-1:0] vt_len(input logic [VT_CW-1:0] v);
        return (v == '0) ? VT_CW'(1) : v;
    endfunction

endpackage

// File: rtl/video_timing_axis_cnt.sv
// video_timing_axis_cnt: one raster axis, stepping SYNC/BP/ACT/FP with an in-phase counter.
module video_timing_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int CW = VT_CW
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_adv,
    input  logic [3:0][CW-1:0]  i_len,
    output vt_phase_e           o_phase,
    output logic [CW-1:0]       o_cnt,
    output logic                o_wrap
);

    logic last;

    assign last   = o_cnt == i_len[o_phase] - CW'(1);
    assign o_wrap = i_adv && last && o_phase == PH_FP;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            o_phase <= PH_SYNC;
            o_cnt   <= '0;
        end else if (i_adv) begin
            o_phase <= last ? vt_phase_e'(o_phase + 2'd1) : o_phase;
            o_cnt   <= last ? '0 : o_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable VSYNC/HSYNC/DEN/DATA raster source with test patterns.
// Counters run one pixel ahead of the output registers, which latch the decode of their position.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int DW       = 8,
    parameter int CW       = VT_CW,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    input  logic          i_en,
    input  logic [1:0]    i_pattern_sel,
    input  logic [DW-1:0] i_const,
    input  logic [CW-1:0] i_hsw,
    input  logic [CW-1:0] i_hbp,
    input  logic [CW-1:0] i_hact,
    input  logic [CW-1:0] i_hfp,
    input  logic [CW-1:0] i_vsw,
    input  logic [CW-1:0] i_vbp,
    input  logic [CW-1:0] i_vact,
    input  logic [CW-1:0] i_vfp,
    output logic          o_VSYNC,
    output logic          o_HSYNC,
    output logic          o_DEN,
    output logic [DW-1:0] o_DATA,
    output logic          o_frame_start,
    output logic          o_busy,
    output logic [CW-1:0] o_frame_cnt
);

    vt_state_e     st;
    vt_cfg_t       sh;
    vt_cfg_t       cfg;
    vt_phase_e     h_ph;
    vt_phase_e     v_ph;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          eof;
    logic          load;
    logic          run_nxt;
    logic          den;
    logic [DW-1:0] pix;
    logic [DW-1:0] pix_nxt;
    logic [DW-1:0] data;

    // eof marks that the counters have just wrapped back to pixel 0 of line 0.
    assign load    = i_en && (st == ST_IDLE || eof);
    assign run_nxt = load || (st == ST_RUN && !eof);
    assign cfg     = load ? vt_cfg_t'{vt_len(i_hsw), vt_len(i_hbp), vt_len(i_hact), vt_len(i_hfp),
                                      vt_len(i_vsw), vt_len(i_vbp), vt_len(i_vact), vt_len(i_vfp)}
                          : sh;

    video_timing_axis_cnt #(.CW(CW)) u_h (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_adv   (run_nxt),
        .i_len   ({cfg.hfp, cfg.hact, cfg.hbp, cfg.hsw}),
        .o_phase (h_ph),
        .o_cnt   (h_cnt),
        .o_wrap  (h_wrap)
    );

    video_timing_axis_cnt #(.CW(CW)) u_v (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .i_adv   (h_wrap),
        .i_len   ({cfg.vfp, cfg.vact, cfg.vbp, cfg.vsw}),
        .o_phase (v_ph),
        .o_cnt   (v_cnt),
        .o_wrap  (v_wrap)
    );

    assign den     = h_ph == PH_ACT && v_ph == PH_ACT;
    assign pix_nxt = load ? '0 : pix;
    assign data    = i_pattern_sel == 2'd0 ? pix_nxt :
                     i_pattern_sel == 2'd1 ? DW'(h_cnt) :
                     i_pattern_sel == 2'd2 ? DW'(v_cnt) : i_const;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            st            <= ST_IDLE;
            sh            <= '0;
            eof           <= 1'b0;
            pix           <= '0;
            o_frame_cnt   <= '0;
            o_VSYNC       <= !SYNC_POL;
            o_HSYNC       <= !SYNC_POL;
            o_DEN         <= 1'b0;
            o_DATA        <= '0;
            o_frame_start <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            st            <= run_nxt ? ST_RUN : ST_IDLE;
            eof           <= v_wrap;
            sh            <= load ? cfg : sh;
            pix           <= run_nxt ? pix_nxt + DW'(den) : '0;
            o_frame_cnt   <= (st == ST_RUN && eof) ? o_frame_cnt + CW'(1) : o_frame_cnt;
            o_VSYNC       <= run_nxt ? (v_ph == PH_SYNC) ~^ SYNC_POL : !SYNC_POL;
            o_HSYNC       <= run_nxt ? (h_ph == PH_SYNC) ~^ SYNC_POL : !SYNC_POL;
            o_DEN         <= run_nxt && den;
            o_DATA        <= (run_nxt && den) ? data : '0;
            o_frame_start <= load;
            o_busy        <= run_nxt;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized checks of video_timing_gen against a raster arithmetic model.
// A second instance with inverted sync polarity shares every input.
module tb_video_timing_gen;

    typedef struct {int hsw, hbp, hact, hfp, vsw, vbp, vact, vfp;} cfg_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  psel;
    logic [7:0]  cst;
    logic [15:0] hsw, hbp, hact, hfp, vsw, vbp, vact, vfp;
    logic        o_vs, o_hs, o_den, o_fs, o_busy;
    logic [7:0]  o_data;
    logic [15:0] o_fcnt;
    logic        n_vs, n_hs, n_den, n_fs, n_busy;
    logic [7:0]  n_data;
    logic [15:0] n_fcnt;

    int n_chk = 0;
    int n_pass = 0;
    int fdone = 0;
    cfg_t base = '{2, 3, 8, 4, 2, 1, 4, 2};

    video_timing_gen #(.DW(8), .CW(16), .SYNC_POL(1'b1)) u_dut (
        .i_CLK(clk), .i_RST(rst), .i_en(en), .i_pattern_sel(psel), .i_const(cst),
        .i_hsw(hsw), .i_hbp(hbp), .i_hact(hact), .i_hfp(hfp),
        .i_vsw(vsw), .i_vbp(vbp), .i_vact(vact), .i_vfp(vfp),
        .o_VSYNC(o_vs), .o_HSYNC(o_hs), .o_DEN(o_den), .o_DATA(o_data),
        .o_frame_start(o_fs), .o_busy(o_busy), .o_frame_cnt(o_fcnt)
    );

    video_timing_gen #(.DW(8), .CW(16), .SYNC_POL(1'b0)) u_dut_n (
        .i_CLK(clk), .i_RST(rst), .i_en(en), .i_pattern_sel(psel), .i_const(cst),
        .i_hsw(hsw), .i_hbp(hbp), .i_hact(hact), .i_hfp(hfp),
        .i_vsw(vsw), .i_vbp(vbp), .i_vact(vact), .i_vfp(vfp),
        .o_VSYNC(n_vs), .o_HSYNC(n_hs), .o_DEN(n_den), .o_DATA(n_data),
        .o_frame_start(n_fs), .o_busy(n_busy), .o_frame_cnt(n_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mx1(input int v);
        return v < 1 ? 1 : v;
    endfunction

    function automatic cfg_t norm(input cfg_t c);
        cfg_t r;
        r = '{mx1(c.hsw), mx1(c.hbp), mx1(c.hact), mx1(c.hfp),
              mx1(c.vsw), mx1(c.vbp), mx1(c.vact), mx1(c.vfp)};
        return r;
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t r;
        r = '{int'($urandom_range(4, 0)), int'($urandom_range(4, 0)), int'($urandom_range(6, 0)),
              int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), int'($urandom_range(3, 0))};
        return r;
    endfunction

    // Expected {VSYNC, HSYNC, DEN, DATA, frame_start, busy, frame_cnt} for clock k of a frame.
    function automatic logic [28:0] exp_vec(input cfg_t n, input int k, input int p,
                                            input logic [7:0] c, input logic [15:0] fc);
        int ht, x, y, ax, ay;
        logic dn;
        logic [7:0] d;
        ht = n.hsw + n.hbp + n.hact + n.hfp;
        x  = k % ht;
        y  = k / ht;
        ax = x - n.hsw - n.hbp;
        ay = y - n.vsw - n.vbp;
        dn = ax >= 0 && ax < n.hact && ay >= 0 && ay < n.vact;
        d  = !dn ? 8'h00 : p == 0 ? 8'(ay * n.hact + ax) : p == 1 ? 8'(ax) : p == 2 ? 8'(ay) : c;
        return {y < n.vsw, x < n.hsw, dn, d, k == 0, 1'b1, fc};
    endfunction

    task automatic drive_cfg(input cfg_t c);
        hsw = 16'(c.hsw); hbp = 16'(c.hbp); hact = 16'(c.hact); hfp = 16'(c.hfp);
        vsw = 16'(c.vsw); vbp = 16'(c.vbp); vact = 16'(c.vact); vfp = 16'(c.vfp);
    endtask

    // Plays one frame loaded with c; psel_fix < 0 picks a random pattern every pixel.
    task automatic play_frame(input cfg_t c, input int psel_fix, input int stop_at, input int drop_at,
                              input int chg_at, input cfg_t nxt, input logic [15:0] fc,
                              output int den_n, output int vs_n, output int hs_rise);
        cfg_t n;
        int ht, lim, p;
        logic [28:0] e;
        logic prev_hs;
        n   = norm(c);
        ht  = n.hsw + n.hbp + n.hact + n.hfp;
        lim = stop_at < 0 ? ht * (n.vsw + n.vbp + n.vact + n.vfp) : stop_at;
        den_n = 0; vs_n = 0; hs_rise = 0; prev_hs = 1'b0;
        for (int k = 0; k < lim; k++) begin
            if (k == drop_at) en = 1'b0;
            if (k == chg_at) drive_cfg(nxt);
            p = psel_fix < 0 ? int'($urandom_range(3, 0)) : psel_fix;
            psel = 2'(p);
            cst = 8'($urandom);
            @(posedge clk); #1;
            e = exp_vec(n, k, p, cst, fc);
            n_chk++;
            if ({o_vs, o_hs, o_den, o_data, o_fs, o_busy, o_fcnt} !== e)
                $display("FAIL pixel k=%0d: got %h, want %h", k,
                         {o_vs, o_hs, o_den, o_data, o_fs, o_busy, o_fcnt}, e);
            else n_pass++;
            n_chk++;
            if ({n_vs, n_hs, n_den, n_data, n_fs, n_busy, n_fcnt} !== {~e[28:27], e[26:0]})
                $display("FAIL inv_pol pixel k=%0d: got %h, want %h", k,
                         {n_vs, n_hs, n_den, n_data, n_fs, n_busy, n_fcnt}, {~e[28:27], e[26:0]});
            else n_pass++;
            den_n += int'(o_den);
            vs_n += int'(o_vs);
            hs_rise += int'(o_hs && !prev_hs);
            prev_hs = o_hs;
        end
    endtask

    task automatic test_idle(input logic [15:0] fc, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if ({o_vs, o_hs, o_den, o_data, o_fs, o_busy, o_fcnt} !== {13'h0, fc})
                $display("FAIL idle: got %h, want %h", {o_vs, o_hs, o_den, o_data, o_fs, o_busy, o_fcnt}, {13'h0, fc});
            else n_pass++;
            n_chk++;
            if ({n_vs, n_hs, n_den, n_data, n_busy} !== 12'hc00)
                $display("FAIL idle_inv: got %h, want c00", {n_vs, n_hs, n_den, n_data, n_busy});
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; psel = 2'd0; cst = 8'h00;
        drive_cfg(base);
        test_idle(16'd0, 2);
        rst = 1'b0;
        test_idle(16'd0, 4);
    endtask

    task automatic test_en_drop();
        int d, v, h;
        en = 1'b1;
        play_frame(base, 0, -1, 60, -1, base, 16'(fdone), d, v, h);
        n_chk++;
        if (d !== 32) $display("FAIL drop_den_count: got %0d, want 32", d); else n_pass++;
        fdone++;
        n_chk++;
        if (fdone !== 1) $display("FAIL drop_frame_total: got %0d, want 1", fdone); else n_pass++;
        test_idle(16'(fdone), 4);
    endtask

    task automatic test_baseline();
        int d, v, h;
        en = 1'b1;
        for (int f = 0; f < 2; f++) begin
            play_frame(base, f == 0 ? 0 : -1, -1, f == 1 ? 100 : -1, -1, base, 16'(fdone), d, v, h);
            fdone++;
            n_chk++;
            if (d !== 32) $display("FAIL base_den_count: got %0d, want 32", d); else n_pass++;
            n_chk++;
            if (v !== 34) $display("FAIL base_vsync_width: got %0d, want 34", v); else n_pass++;
            n_chk++;
            if (h !== 9) $display("FAIL base_hsync_pulses: got %0d, want 9", h); else n_pass++;
        end
        test_idle(16'(fdone), 3);
    endtask

    task automatic test_mid_change();
        int d, v, h;
        cfg_t c6;
        c6 = base;
        c6.hact = 6;
        en = 1'b1;
        play_frame(base, -1, -1, -1, 40, c6, 16'(fdone), d, v, h);
        fdone++;
        n_chk++;
        if (d !== 32) $display("FAIL chg_cur_den: got %0d, want 32", d); else n_pass++;
        play_frame(c6, 0, -1, 30, 20, rand_cfg(), 16'(fdone), d, v, h);
        fdone++;
        n_chk++;
        if (d !== 24) $display("FAIL chg_next_den: got %0d, want 24", d); else n_pass++;
        n_chk++;
        if (v !== 30) $display("FAIL chg_next_vsync: got %0d, want 30 (2 lines of 15)", v); else n_pass++;
        test_idle(16'(fdone), 2);
    endtask

    task automatic test_zero_fields();
        int d, v, h;
        cfg_t z;
        z = base;
        z.hbp = 0;
        z.vfp = 0;
        drive_cfg(z);
        en = 1'b1;
        play_frame(z, 0, -1, 10, -1, z, 16'(fdone), d, v, h);
        fdone++;
        n_chk++;
        if (d !== 32) $display("FAIL zero_den: got %0d, want 32", d); else n_pass++;
        n_chk++;
        if (h !== 8) $display("FAIL zero_vtotal_lines: got %0d, want 8", h); else n_pass++;
        test_idle(16'(fdone), 2);
    endtask

    task automatic test_back_to_back();
        int d, v, h;
        cfg_t cs[7];
        for (int i = 0; i < 7; i++) cs[i] = rand_cfg();
        drive_cfg(cs[0]);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            play_frame(cs[i], -1, -1, i == 5 ? 2 : -1, 1, cs[i + 1], 16'(fdone), d, v, h);
            fdone++;
            n_chk++;
            if (d !== mx1(cs[i].vact) * mx1(cs[i].hact))
                $display("FAIL b2b_den frame %0d: got %0d, want %0d", i, d, mx1(cs[i].vact) * mx1(cs[i].hact));
            else n_pass++;
        end
        test_idle(16'(fdone), 2);
    endtask

    task automatic test_reset_mid();
        int d, v, h;
        drive_cfg(base);
        en = 1'b1;
        play_frame(base, 0, 70, -1, -1, base, 16'(fdone), d, v, h);
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({o_vs, o_hs, o_den, o_data, o_fs, o_busy, o_fcnt} !== 29'h0)
            $display("FAIL async_reset: got %h, want 0", {o_vs, o_hs, o_den, o_data, o_fs, o_busy, o_fcnt});
        else n_pass++;
        n_chk++;
        if ({n_vs, n_hs, n_den, n_busy} !== 4'b1100)
            $display("FAIL async_reset_inv: got %b, want 1100", {n_vs, n_hs, n_den, n_busy});
        else n_pass++;
        fdone = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        play_frame(base, -1, -1, 5, -1, base, 16'(fdone), d, v, h);
        fdone++;
        n_chk++;
        if (d !== 32) $display("FAIL post_reset_den: got %0d, want 32", d); else n_pass++;
        test_idle(16'(fdone), 2);
    endtask

    initial begin
        test_reset();
        test_en_drop();
        test_baseline();
        test_mid_change();
        test_zero_fields();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
